// File: rtl/dff_bank_actmon.sv
// Multi-bit register bank with reset value, load enable and a scan shift path.
// It also has a switching-activity monitor. The monitor counts Q bit toggles
// over WINDOW monitored cycles and reports the total on ACT_CNT.
module dff_bank_actmon #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               WINDOW    = 256,
    parameter int               CNT_W     = 16
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    input  logic             SE,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             SO,
    input  logic             MON_EN,
    output logic [CNT_W-1:0] ACT_CNT,
    output logic             ACT_VALID,
    output logic             ACT_SAT
);

    localparam int               T_W     = $clog2(WIDTH + 1);
    localparam int               WC_W    = $clog2(WINDOW);
    localparam logic [WC_W-1:0]  WLAST   = WC_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] act_cnt_q, act_cnt_d;
    logic             act_valid_q, act_valid_d;
    logic             act_sat_q, act_sat_d;

    logic [WIDTH-1:0] scan_val;
    logic [T_W-1:0]   tog_cnt;
    logic [CNT_W:0]   sum;
    logic             sum_ovf;
    logic [CNT_W-1:0] acc_clamped;
    logic             mon_cycle;

    // A one-bit bank has no lower bits to shift, so SI loads directly.
    generate
        if (WIDTH == 1) begin : g_scan_1
            assign scan_val = SI;
        end else begin : g_scan_n
            assign scan_val = {q_q[WIDTH-2:0], SI};
        end
    endgenerate

    // Data path next state: scan has priority over the load enable.
    always_comb begin
        q_d = q_q;
        if (SE) begin
            q_d = scan_val;
        end else if (EN) begin
            q_d = D;
        end
    end

    // Count the bits that this edge will flip. This is the popcount of Qnext ^ Q.
    always_comb begin
        tog_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tog_cnt = tog_cnt + T_W'(q_d[i] ^ q_q[i]);
        end
    end

    // Add the toggles with one extra carry bit. Clamp to all-ones so the count never wraps.
    assign sum         = {1'b0, acc_q} + (CNT_W + 1)'(tog_cnt);
    assign sum_ovf     = sum[CNT_W];
    assign acc_clamped = sum_ovf ? CNT_MAX : sum[CNT_W-1:0];
    assign mon_cycle   = MON_EN & ~SE;

    // Window accumulation and the report on the closing monitored edge.
    always_comb begin
        acc_d       = acc_q;
        wcnt_d      = wcnt_q;
        sat_d       = sat_q;
        act_cnt_d   = act_cnt_q;
        act_sat_d   = act_sat_q;
        act_valid_d = 1'b0;
        if (mon_cycle) begin
            if (wcnt_q == WLAST) begin
                act_cnt_d   = acc_clamped;
                act_sat_d   = sat_q | sum_ovf;
                act_valid_d = 1'b1;
                acc_d       = '0;
                wcnt_d      = '0;
                sat_d       = 1'b0;
            end else begin
                acc_d  = acc_clamped;
                wcnt_d = wcnt_q + WC_W'(1);
                sat_d  = sat_q | sum_ovf;
            end
        end
    end

    // State registers. Reset drops any partial window.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            q_q         <= RESET_VAL;
            acc_q       <= '0;
            wcnt_q      <= '0;
            sat_q       <= 1'b0;
            act_cnt_q   <= '0;
            act_valid_q <= 1'b0;
            act_sat_q   <= 1'b0;
        end else begin
            q_q         <= q_d;
            acc_q       <= acc_d;
            wcnt_q      <= wcnt_d;
            sat_q       <= sat_d;
            act_cnt_q   <= act_cnt_d;
            act_valid_q <= act_valid_d;
            act_sat_q   <= act_sat_d;
        end
    end

    assign Q         = q_q;
    assign QN        = ~q_q;
    assign SO        = q_q[WIDTH-1];
    assign ACT_CNT   = act_cnt_q;
    assign ACT_VALID = act_valid_q;
    assign ACT_SAT   = act_sat_q;

endmodule

// File: tb/tb_dff_bank_actmon.sv
// Bench for dff_bank_actmon. Two instances share one set of inputs.
// Both use WIDTH=8, RESET_VAL=A5 and WINDOW=4. Instance 0 has CNT_W=16; instance 1 has CNT_W=4, which saturates.
module tb_dff_bank_actmon;

    localparam int WINDOW = 4;

    logic        CK, RST, EN, SE, SI, MON_EN;
    logic [7:0]  D;
    logic [7:0]  q0, qn0, q1, qn1;
    logic        so0, so1, valid0, valid1, sat0, sat1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    int total = 0;
    int bad   = 0;

    dff_bank_actmon #(.WIDTH(8), .RESET_VAL(8'hA5), .WINDOW(WINDOW), .CNT_W(16)) dut0 (
        .CK(CK), .RST(RST), .EN(EN), .D(D), .SE(SE), .SI(SI),
        .Q(q0), .QN(qn0), .SO(so0), .MON_EN(MON_EN),
        .ACT_CNT(cnt0), .ACT_VALID(valid0), .ACT_SAT(sat0)
    );

    dff_bank_actmon #(.WIDTH(8), .RESET_VAL(8'hA5), .WINDOW(WINDOW), .CNT_W(4)) dut1 (
        .CK(CK), .RST(RST), .EN(EN), .D(D), .SE(SE), .SI(SI),
        .Q(q1), .QN(qn1), .SO(so1), .MON_EN(MON_EN),
        .ACT_CNT(cnt1), .ACT_VALID(valid1), .ACT_SAT(sat1)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Reference model: the register value plus per-instance window bookkeeping, as plain integers.
    logic [7:0] m_q;
    int         cw[2] = '{16, 4};
    int         m_acc[2], m_wcnt[2], m_cnt[2];
    bit         m_satf[2], m_sat[2], m_valid[2];

    function automatic void model_reset();
        m_q = 8'hA5;
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_wcnt[k] = 0; m_cnt[k] = 0;
            m_satf[k] = 0; m_sat[k] = 0; m_valid[k] = 0;
        end
    endfunction

    function automatic void model_edge();
        logic [7:0] nq;
        int t, tot, maxv;
        if (SE) nq = {m_q[6:0], SI};
        else if (EN) nq = D;
        else nq = m_q;
        t = $countones(nq ^ m_q);
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0;
            if (MON_EN && !SE) begin
                maxv = (1 << cw[k]) - 1;
                tot  = m_acc[k] + t;
                if (tot > maxv) begin
                    tot = maxv;
                    m_satf[k] = 1;
                end
                if (m_wcnt[k] == WINDOW - 1) begin
                    m_cnt[k] = tot; m_sat[k] = m_satf[k]; m_valid[k] = 1;
                    m_acc[k] = 0; m_wcnt[k] = 0; m_satf[k] = 0;
                end else begin
                    m_acc[k] = tot;
                    m_wcnt[k]++;
                end
            end
        end
        m_q = nq;
    endfunction

    // Advance one rising edge. The model sees the inputs as they stand just before the edge.
    task automatic tick();
        model_edge();
        @(posedge CK);
        #1;
    endtask

    // Pulse reset between edges.
    task automatic do_reset();
        #1 RST = 1'b1;
        model_reset();
        #1 RST = 1'b0;
    endtask

    task automatic test_reset();
        EN = 1'b1; D = 8'h3C; SE = 1'b0; MON_EN = 1'b0;
        tick();
        #2 RST = 1'b1;
        model_reset();
        #1;
        total++; if (q0 !== 8'hA5) begin bad++; $display("FAIL reset_q got=%h exp=a5", q0); end
        total++; if (qn0 !== 8'h5A) begin bad++; $display("FAIL reset_qn got=%h exp=5a", qn0); end
        total++; if (so0 !== 1'b1) begin bad++; $display("FAIL reset_so got=%b exp=1", so0); end
        total++; if (cnt0 !== 16'd0 || valid0 !== 1'b0 || sat0 !== 1'b0)
            begin bad++; $display("FAIL reset_act got=%0d/%b/%b exp=0/0/0", cnt0, valid0, sat0); end
        total++; if (q1 !== 8'hA5 || cnt1 !== 4'd0) begin bad++; $display("FAIL reset_dut1 got=%h/%0d exp=a5/0", q1, cnt1); end
        #1 RST = 1'b0;
    endtask

    task automatic test_load_hold();
        SE = 1'b0; MON_EN = 1'b0; EN = 1'b1; D = 8'h3C;
        tick();
        total++; if (q0 !== 8'h3C) begin bad++; $display("FAIL load got=%h exp=3c", q0); end
        EN = 1'b0; D = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (q0 !== 8'h3C) begin bad++; $display("FAIL hold[%0d] got=%h exp=3c", i, q0); end
        end
    endtask

    task automatic test_scan();
        logic [7:0] sibits;
        logic [7:0] exp_q;
        sibits = 8'b1011_0010;
        EN = 1'b1; D = 8'h00; MON_EN = 1'b0; SE = 1'b0;
        tick();
        exp_q = 8'h00;
        SE = 1'b1; EN = 1'b1; D = 8'hFF; MON_EN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            SI = sibits[7-i];
            tick();
            exp_q = {exp_q[6:0], sibits[7-i]};
            total++; if (q0 !== exp_q || so0 !== exp_q[7])
                begin bad++; $display("FAIL scan_shift[%0d] got=%h/%b exp=%h/%b", i, q0, so0, exp_q, exp_q[7]); end
            total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL scan_valid[%0d] got=%b exp=0", i, valid0); end
        end
        total++; if (q0 !== 8'hB2) begin bad++; $display("FAIL scan_final got=%h exp=b2", q0); end
        // The scan cycles must not have started a window.
        SE = 1'b0; EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (valid0 !== (i == 3)) begin bad++; $display("FAIL scan_win_valid[%0d] got=%b exp=%b", i, valid0, (i == 3)); end
        end
        total++; if (cnt0 !== 16'd0) begin bad++; $display("FAIL scan_win_cnt got=%0d exp=0", cnt0); end
    endtask

    task automatic test_window();
        do_reset();
        SE = 1'b0; MON_EN = 1'b0; EN = 1'b1; D = 8'h00;
        tick();
        MON_EN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            D = (i % 2 == 0) ? 8'hFF : 8'h00;
            tick();
            total++; if (valid0 !== (i == 3) || valid1 !== (i == 3))
                begin bad++; $display("FAIL win_valid[%0d] got=%b/%b exp=%b", i, valid0, valid1, (i == 3)); end
        end
        total++; if (cnt0 !== 16'd32 || sat0 !== 1'b0) begin bad++; $display("FAIL win_cnt got=%0d/%b exp=32/0", cnt0, sat0); end
        total++; if (cnt1 !== 4'd15 || sat1 !== 1'b1) begin bad++; $display("FAIL win_sat got=%0d/%b exp=15/1", cnt1, sat1); end
        EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin
                total++; if (valid0 !== 1'b0 || cnt0 !== 16'd32)
                    begin bad++; $display("FAIL win_hold got=%b/%0d exp=0/32", valid0, cnt0); end
            end
        end
        total++; if (valid0 !== 1'b1 || cnt0 !== 16'd0 || sat0 !== 1'b0)
            begin bad++; $display("FAIL win_idle got=%b/%0d/%b exp=1/0/0", valid0, cnt0, sat0); end
        total++; if (cnt1 !== 4'd0 || sat1 !== 1'b0) begin bad++; $display("FAIL win_idle_sat got=%0d/%b exp=0/0", cnt1, sat1); end
    endtask

    task automatic test_pause_reset();
        do_reset();
        SE = 1'b0; MON_EN = 1'b0; EN = 1'b1; D = 8'h00;
        tick();
        MON_EN = 1'b1; D = 8'hFF; tick();
        D = 8'h00; tick();
        MON_EN = 1'b0; EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL pause_valid[%0d] got=%b exp=0", i, valid0); end
        end
        MON_EN = 1'b1; EN = 1'b1; D = 8'hFF; tick();
        total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL pause_early got=%b exp=0", valid0); end
        D = 8'h00; tick();
        total++; if (valid0 !== 1'b1 || cnt0 !== 16'd32) begin bad++; $display("FAIL pause_report got=%b/%0d exp=1/32", valid0, cnt0); end
        // Abandon a window part-way through by applying reset.
        D = 8'hFF; tick();
        D = 8'h00; tick();
        total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL pre_rst_valid got=%b exp=0", valid0); end
        do_reset();
        total++; if (q0 !== 8'hA5 || cnt0 !== 16'd0) begin bad++; $display("FAIL mid_rst got=%h/%0d exp=a5/0", q0, cnt0); end
        for (int i = 0; i < 4; i++) begin
            D = (i % 2 == 0) ? 8'hFF : 8'h00;
            tick();
            total++; if (valid0 !== (i == 3)) begin bad++; $display("FAIL post_rst_valid[%0d] got=%b exp=%b", i, valid0, (i == 3)); end
        end
        total++; if (cnt0 !== 16'd28 || sat0 !== 1'b0) begin bad++; $display("FAIL post_rst_cnt got=%0d/%b exp=28/0", cnt0, sat0); end
        total++; if (cnt1 !== 4'd15 || sat1 !== 1'b1) begin bad++; $display("FAIL post_rst_sat got=%0d/%b exp=15/1", cnt1, sat1); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            SE     = ($urandom_range(0, 7) == 0);
            EN     = $urandom_range(0, 1);
            D      = 8'($urandom);
            SI     = $urandom_range(0, 1);
            MON_EN = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) do_reset();
            tick();
            total++; if (q0 !== m_q || qn0 !== ~m_q || so0 !== m_q[7] || q1 !== m_q)
                begin bad++; $display("FAIL rnd_q[%0d] got=%h/%h/%b exp=%h", n, q0, qn0, so0, m_q); end
            total++; if (cnt0 !== 16'(m_cnt[0]) || valid0 !== m_valid[0] || sat0 !== m_sat[0])
                begin bad++; $display("FAIL rnd_act0[%0d] got=%0d/%b/%b exp=%0d/%b/%b", n, cnt0, valid0, sat0, m_cnt[0], m_valid[0], m_sat[0]); end
            total++; if (cnt1 !== 4'(m_cnt[1]) || valid1 !== m_valid[1] || sat1 !== m_sat[1])
                begin bad++; $display("FAIL rnd_act1[%0d] got=%0d/%b/%b exp=%0d/%b/%b", n, cnt1, valid1, sat1, m_cnt[1], m_valid[1], m_sat[1]); end
        end
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; D = 8'h00; SE = 1'b0; SI = 1'b0; MON_EN = 1'b0;
        model_reset();
        #12 RST = 1'b0;
        test_reset();
        test_load_hold();
        test_scan();
        test_window();
        test_pause_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dff_bank_actmon.md
Name: dff_bank_actmon

Overview:
- Parametrised multi-bit register bank: the next generation of the single-bit DFF cells.
- Adds per-bank reset value, load enable and a scan shift path.
- Adds an in-silicon switching-activity monitor that counts Q bit toggles over a programmable window, for FPU power and activity characterisation.
- Placed in datapath pipeline stages in place of rows of discrete flops.

Parameters:
- WIDTH, 8, number of register bits; legal range ≥1.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q on reset.
- WINDOW, 256, monitored cycles per activity report; legal range ≥2.
- CNT_W, 16, activity counter width; must be ≥ clog2(WIDTH+1).

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous reset, active-high.
- EN  input  1  load enable for D.
- D  input  WIDTH  data input.
- SE  input  1  scan enable; overrides EN.
- SI  input  1  scan serial input.
- Q  output  WIDTH  register state.
- QN  output  WIDTH  ~Q.
- SO  output  1  scan serial output, equal to Q[WIDTH-1].
- MON_EN  input  1  activity monitor enable.
- ACT_CNT  output  CNT_W  toggle count of the last completed window.
- ACT_VALID  output  1  one-cycle pulse when ACT_CNT updates.
- ACT_SAT  output  1  last completed window saturated.

Behaviour:
- Reset (async, RST=1, effective immediately with no clock):
  - Q=RESET_VAL, QN=~RESET_VAL, SO=RESET_VAL[WIDTH-1].
  - ACT_CNT=0, ACT_VALID=0, ACT_SAT=0.
  - Internal accumulator acc=0, window counter wcnt=0.
  - While RST=1, CK edges are ignored.
- Next-state priority, evaluated at each rising CK edge:
  - SE=1: Q <= {Q[WIDTH-2:0], SI}. For WIDTH=1, Q <= SI.
  - else EN=1: Q <= D.
  - else Q holds.
  - Latency D→Q is one edge.
- QN and SO are purely combinational from Q. No other combinational input-to-output path exists.
- Per-cycle toggle count: t = popcount(Qnext ^ Q), width clog2(WIDTH+1).
- Monitored cycle = rising edge with MON_EN=1 and SE=0.
  - Scan cycles are never counted.
  - Cycles with MON_EN=0 pause both wcnt and acc; they do not clear them.
- On a monitored cycle with wcnt < WINDOW-1:
  - acc <= sat(acc + t); wcnt <= wcnt+1.
- On a monitored cycle with wcnt == WINDOW-1:
  - ACT_CNT <= sat(acc + t).
  - ACT_SAT <= 1 if saturation occurred at any point in this window, else 0.
  - ACT_VALID <= 1 for exactly one cycle.
  - acc <= 0; wcnt <= 0; the sticky saturation flag is cleared.
- sat() clamps to 2^CNT_W-1. Once clamped, acc never wraps.
- ACT_CNT and ACT_SAT hold between reports.
- ACT_VALID returns to 0 on the next edge, regardless of MON_EN.
- SE=1 on the window-closing edge: that edge is not monitored, so the window closes on the next monitored edge.
- Reset mid-window: partial acc is discarded and no ACT_VALID is produced for that window.
- wcnt width is clog2(WINDOW).

Test Plan:
1. Reset value: WIDTH=8, RESET_VAL=8'hA5; pulse RST asynchronously between edges → Q=A5, QN=5A and SO=1 before the next edge; ACT_CNT=0, ACT_VALID=0.
2. Load and hold:
   - EN=1, D=8'h3C → Q=3C after one edge.
   - Then EN=0, D=FF for 3 edges → Q stays 3C.
   - SE=0 throughout.
3. Scan priority:
   - From Q=8'h00, SE=1, EN=1, D=FF, SI=1,0,1,1,0,0,1,0 over 8 edges → Q=8'hB2, D ignored.
   - SO after each edge = Q[7] of the shifted value.
   - Same run with MON_EN=1 → no monitored cycles, no ACT_VALID, acc stays 0.
4. Activity window:
   - WINDOW=4, MON_EN=1, EN=1, D alternating FF,00,FF,00 from Q=00 → each edge t=8.
   - After the 4th edge, ACT_CNT=32, ACT_SAT=0, ACT_VALID high one cycle.
   - Next window with EN=0 → ACT_CNT=0.
5. Saturation: CNT_W=4, WINDOW=4, same stimulus as scenario 4 → ACT_CNT=15 and ACT_SAT=1; the following window with EN=0 reports ACT_CNT=0 and ACT_SAT=0.
6. Pause and reset:
   - WINDOW=4, MON_EN dropped for 3 edges after 2 monitored edges → ACT_VALID arrives on the 4th monitored edge (7th edge overall) with ACT_CNT=32.
   - Repeat, asserting RST after 2 monitored edges → no ACT_VALID from that window; the next full window reports only its own toggles.
